// File: rtl/stoplight_pkg.sv
// Shared phase codes, error codes and default phase lengths for the stoplight
// monitor and the controller bench.
package stoplight_pkg;

    typedef logic [2:0] phase_t;
    typedef logic [2:0] err_code_t;

    localparam phase_t PH_AG      = 3'd0;
    localparam phase_t PH_AY      = 3'd1;
    localparam phase_t PH_BG      = 3'd2;
    localparam phase_t PH_BY      = 3'd3;
    localparam phase_t PH_WALK    = 3'd4;
    localparam phase_t PH_FLASH   = 3'd5;
    localparam phase_t PH_INVALID = 3'd7;

    localparam err_code_t ERR_NONE  = 3'd0;
    localparam err_code_t ERR_COMBO = 3'd1;
    localparam err_code_t ERR_TRANS = 3'd2;
    localparam err_code_t ERR_SHORT = 3'd3;
    localparam err_code_t ERR_LONG  = 3'd4;
    localparam err_code_t ERR_FLASH = 3'd5;

    localparam logic [7:0] T_AG_DEF    = 8'd4;
    localparam logic [7:0] T_AY_DEF    = 8'd2;
    localparam logic [7:0] T_BG_DEF    = 8'd3;
    localparam logic [7:0] T_BY_DEF    = 8'd2;
    localparam logic [7:0] T_WALK_DEF  = 8'd2;
    localparam logic [7:0] T_FLASH_DEF = 8'd3;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_AG:    next_phase = PH_AY;
            PH_AY:    next_phase = PH_BG;
            PH_BG:    next_phase = PH_BY;
            PH_BY:    next_phase = PH_WALK;
            PH_WALK:  next_phase = PH_FLASH;
            PH_FLASH: next_phase = PH_AG;
            default:  next_phase = PH_INVALID;
        endcase
    endfunction

endpackage

// File: rtl/light_decode.sv
// Combinational decode of the eight light lines into a phase code; any
// combination other than the six legal ones decodes as INVALID.
module light_decode
    import stoplight_pkg::*;
(
    input  logic       Ra,
    input  logic       Ya,
    input  logic       Ga,
    input  logic       Rb,
    input  logic       Yb,
    input  logic       Gb,
    input  logic       Rw,
    input  logic       Gw,
    output logic [2:0] phase
);

    logic [7:0] lights;

    assign lights = {Ra, Ya, Ga, Rb, Yb, Gb, Rw, Gw};

    always_comb begin
        case (lights)
            8'b0011_0010:               phase = PH_AG;
            8'b0101_0010:               phase = PH_AY;
            8'b1000_0110:               phase = PH_BG;
            8'b1000_1010:               phase = PH_BY;
            8'b1001_0001:               phase = PH_WALK;
            // Pedestrian red flashes, so Rw is a don't-care here
            8'b1001_0010, 8'b1001_0000: phase = PH_FLASH;
            default:                    phase = PH_INVALID;
        endcase
    end

endmodule

// File: rtl/stoplight_monitor.sv
// Passive checker for a stoplight controller: decodes the lights, tracks
// phase run lengths and sequence alignment, and latches the first error.
module stoplight_monitor
    import stoplight_pkg::*;
#(
    parameter logic [7:0] T_AG    = T_AG_DEF,
    parameter logic [7:0] T_AY    = T_AY_DEF,
    parameter logic [7:0] T_BG    = T_BG_DEF,
    parameter logic [7:0] T_BY    = T_BY_DEF,
    parameter logic [7:0] T_WALK  = T_WALK_DEF,
    parameter logic [7:0] T_FLASH = T_FLASH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Ra,
    input  logic        Ya,
    input  logic        Ga,
    input  logic        Rb,
    input  logic        Yb,
    input  logic        Gb,
    input  logic        Rw,
    input  logic        Gw,
    output logic [2:0]  phase,
    output logic        locked,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [15:0] rounds
);

    localparam logic ST_UNLOCKED = 1'b0;
    localparam logic ST_LOCKED   = 1'b1;

    logic       state;
    logic [2:0] dec;
    logic [7:0] run_len;
    logic [7:0] flash_rises;
    logic [7:0] t_cur;
    logic       rw_prev;
    logic       changed;
    logic       rise;
    logic       e_combo, e_trans, e_short, e_long, e_flash;
    logic [2:0] code_now;
    logic       any_err;

    light_decode u_decode (
        .Ra    (Ra),
        .Ya    (Ya),
        .Ga    (Ga),
        .Rb    (Rb),
        .Yb    (Yb),
        .Gb    (Gb),
        .Rw    (Rw),
        .Gw    (Gw),
        .phase (dec)
    );

    always_comb begin
        case (phase)
            PH_AG:    t_cur = T_AG;
            PH_AY:    t_cur = T_AY;
            PH_BG:    t_cur = T_BG;
            PH_BY:    t_cur = T_BY;
            PH_WALK:  t_cur = T_WALK;
            PH_FLASH: t_cur = T_FLASH;
            default:  t_cur = '0;
        endcase
    end

    assign locked  = (state == ST_LOCKED);
    assign changed = (dec != phase);
    // Only Rw edges with FLASH on both sides count as seen during FLASH
    assign rise    = (dec == PH_FLASH) && (phase == PH_FLASH) && Rw && !rw_prev;

    assign e_combo = (dec == PH_INVALID);
    assign e_trans = locked && changed && (dec != next_phase(phase));
    assign e_short = locked && changed && (run_len < t_cur);
    assign e_long  = locked && !changed && (run_len == t_cur) && (run_len != 8'hFF);
    assign e_flash = locked && changed && (phase == PH_FLASH) && (flash_rises == 8'd0);

    always_comb begin
        if (e_combo)      code_now = ERR_COMBO;
        else if (e_trans) code_now = ERR_TRANS;
        else if (e_short) code_now = ERR_SHORT;
        else if (e_long)  code_now = ERR_LONG;
        else if (e_flash) code_now = ERR_FLASH;
        else              code_now = ERR_NONE;
    end

    assign any_err = (code_now != ERR_NONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= PH_INVALID;
            state       <= ST_UNLOCKED;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            rounds      <= '0;
            run_len     <= '0;
            flash_rises <= '0;
            rw_prev     <= 1'b0;
        end else begin
            phase   <= dec;
            rw_prev <= Rw;

            if (changed)                 run_len <= 8'd1;
            else if (run_len != 8'hFF)   run_len <= run_len + 8'd1;

            if (changed)                               flash_rises <= '0;
            else if (rise && flash_rises != 8'hFF)     flash_rises <= flash_rises + 8'd1;

            if (any_err && !err) begin
                err      <= 1'b1;
                err_code <= code_now;
            end

            if (any_err)
                state <= ST_UNLOCKED;
            else if (!locked && dec == PH_AG && phase != PH_AG)
                state <= ST_LOCKED;

            if (locked && phase == PH_FLASH && dec == PH_AG && !any_err)
                rounds <= rounds + 16'd1;
        end
    end

endmodule

// File: tb/tb_stoplight_monitor.sv
// Directed bench for stoplight_monitor: a cycle-level reference model of the
// monitoring rules is checked every cycle, plus hand-computed spot checks.
module tb_stoplight_monitor;

    localparam logic [7:0] V_AG  = 8'b0011_0010;
    localparam logic [7:0] V_AY  = 8'b0101_0010;
    localparam logic [7:0] V_BG  = 8'b1000_0110;
    localparam logic [7:0] V_BY  = 8'b1000_1010;
    localparam logic [7:0] V_WK  = 8'b1001_0001;
    localparam logic [7:0] V_F1  = 8'b1001_0010;
    localparam logic [7:0] V_F0  = 8'b1001_0000;
    localparam logic [7:0] V_BAD = 8'b0010_0110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  lv  = V_AG;
    logic [2:0]  phase;
    logic        locked;
    logic        err;
    logic [2:0]  err_code;
    logic [15:0] rounds;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_phase, m_run, m_rises, m_code, m_rounds;
    bit m_locked, m_err, m_prev_rw;
    int t_len [6] = '{4, 2, 3, 2, 2, 3};
    int nxt   [6] = '{1, 2, 3, 4, 5, 0};

    always #5 clk = ~clk;

    stoplight_monitor #(
        .T_AG    (8'd4),
        .T_AY    (8'd2),
        .T_BG    (8'd3),
        .T_BY    (8'd2),
        .T_WALK  (8'd2),
        .T_FLASH (8'd3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Ra       (lv[7]),
        .Ya       (lv[6]),
        .Ga       (lv[5]),
        .Rb       (lv[4]),
        .Yb       (lv[3]),
        .Gb       (lv[2]),
        .Rw       (lv[1]),
        .Gw       (lv[0]),
        .phase    (phase),
        .locked   (locked),
        .err      (err),
        .err_code (err_code),
        .rounds   (rounds)
    );

    function automatic int model_dec(input logic [7:0] v);
        logic ra, ya, ga, rb, yb, gb, rw, gw;
        {ra, ya, ga, rb, yb, gb, rw, gw} = v;
        if (ga && rb && rw && !(ra || ya || yb || gb || gw)) return 0;
        if (ya && rb && rw && !(ra || ga || yb || gb || gw)) return 1;
        if (ra && gb && rw && !(ya || ga || rb || yb || gw)) return 2;
        if (ra && yb && rw && !(ya || ga || rb || gb || gw)) return 3;
        if (ra && rb && gw && !(ya || ga || yb || gb || rw)) return 4;
        if (ra && rb && !(ya || ga || yb || gb || gw))       return 5;
        return 7;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input logic [7:0] v, input logic r);
        int  d, code;
        bit  chg, rw;
        if (r) begin
            m_phase = 7; m_run = 0; m_rises = 0; m_code = 0; m_rounds = 0;
            m_locked = 0; m_err = 0; m_prev_rw = 0;
            return;
        end
        d    = model_dec(v);
        rw   = v[1];
        chg  = (d != m_phase);
        code = 0;
        if (d == 7)                                                        code = 1;
        else if (m_locked && chg && d != nxt[m_phase])                     code = 2;
        else if (m_locked && chg && m_run < t_len[m_phase])                code = 3;
        else if (m_locked && !chg && m_run + 1 == t_len[m_phase] + 1)      code = 4;
        else if (m_locked && chg && m_phase == 5 && m_rises == 0)          code = 5;

        if (code != 0 && !m_err) begin m_err = 1; m_code = code; end
        if (m_locked && m_phase == 5 && d == 0 && code == 0)
            m_rounds = (m_rounds + 1) % 65536;
        if (code != 0)                                 m_locked = 0;
        else if (!m_locked && d == 0 && m_phase != 0)  m_locked = 1;

        if (chg)                                           m_rises = 0;
        else if (d == 5 && rw && !m_prev_rw)               m_rises++;
        m_run     = chg ? 1 : (m_run < 255 ? m_run + 1 : 255);
        m_prev_rw = rw;
        m_phase   = d;
    endtask

    task automatic cyc(input logic [7:0] v, input logic r);
        lv  = v;
        rst = r;
        @(posedge clk);
        model_step(v, r);
        #1;
        check("phase",    32'(phase),    32'(m_phase));
        check("locked",   32'(locked),   32'(m_locked));
        check("err",      32'(err),      32'(m_err));
        check("err_code", 32'(err_code), 32'(m_code));
        check("rounds",   32'(rounds),   32'(m_rounds));
    endtask

    task automatic hold(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) cyc(v, 1'b0);
    endtask

    task automatic do_reset();
        cyc(V_AG, 1'b1);
        cyc(V_AG, 1'b1);
    endtask

    task automatic to_walk(input int ag_n);
        hold(V_AG, ag_n);
        hold(V_AY, 2);
        hold(V_BG, 3);
        hold(V_BY, 2);
        hold(V_WK, 2);
    endtask

    task automatic flash_ok();
        cyc(V_F1, 1'b0);
        cyc(V_F0, 1'b0);
        cyc(V_F1, 1'b0);
    endtask

    initial begin
        // Reset values and three legal rounds
        do_reset();
        check("rst_phase",  32'(phase),    32'd7);
        check("rst_locked", 32'(locked),   32'd0);
        check("rst_err",    32'(err),      32'd0);
        check("rst_code",   32'(err_code), 32'd0);
        check("rst_rounds", 32'(rounds),   32'd0);
        cyc(V_AG, 1'b0);
        check("lock_first_ag", 32'(locked), 32'd1);
        check("lock_phase",    32'(phase),  32'd0);
        to_walk(3);
        flash_ok();
        for (int r = 0; r < 2; r++) begin
            to_walk(4);
            flash_ok();
        end
        cyc(V_AG, 1'b0);
        check("legal_rounds", 32'(rounds), 32'd3);
        check("legal_err",    32'(err),    32'd0);
        check("legal_locked", 32'(locked), 32'd1);

        // Illegal combination
        do_reset();
        cyc(V_AG, 1'b0);
        cyc(V_BAD, 1'b0);
        check("combo_err",    32'(err),      32'd1);
        check("combo_code",   32'(err_code), 32'd1);
        check("combo_locked", 32'(locked),   32'd0);
        check("combo_phase",  32'(phase),    32'd7);

        // Short AY
        do_reset();
        hold(V_AG, 4);
        cyc(V_AY, 1'b0);
        cyc(V_BG, 1'b0);
        check("short_code", 32'(err_code), 32'd3);

        // Long BG flagged on its 4th cycle
        do_reset();
        hold(V_AG, 4);
        hold(V_AY, 2);
        hold(V_BG, 3);
        check("long_before", 32'(err), 32'd0);
        cyc(V_BG, 1'b0);
        check("long_code", 32'(err_code), 32'd4);

        // Long AG then skip to BG: first error wins
        do_reset();
        hold(V_AG, 5);
        check("longag_code", 32'(err_code), 32'd4);
        cyc(V_BG, 1'b0);
        check("longag_keep", 32'(err_code), 32'd4);

        // Exact AG then skip to BG
        do_reset();
        hold(V_AG, 4);
        cyc(V_BG, 1'b0);
        check("trans_code", 32'(err_code), 32'd2);

        // FLASH without Rw toggling
        do_reset();
        to_walk(4);
        hold(V_F1, 3);
        cyc(V_AG, 1'b0);
        check("flash_code",   32'(err_code), 32'd5);
        check("flash_rounds", 32'(rounds),   32'd0);

        // Reset mid-BG discards the partial phase
        hold(V_AG, 4);
        hold(V_AY, 2);
        hold(V_BG, 2);
        cyc(V_BG, 1'b1);
        check("midrst_phase",  32'(phase),    32'd7);
        check("midrst_locked", 32'(locked),   32'd0);
        check("midrst_err",    32'(err),      32'd0);
        check("midrst_code",   32'(err_code), 32'd0);
        check("midrst_rounds", 32'(rounds),   32'd0);
        to_walk(4);
        flash_ok();
        cyc(V_AG, 1'b0);
        check("relock_rounds", 32'(rounds), 32'd1);
        check("relock_err",    32'(err),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stoplight_monitor.md
STOPLIGHT_MONITOR -- requirements
Module: stoplight_monitor

Interface
REQ-001 Parameter T_AG, default 4, required Ga-phase length in clk cycles (1..255).
REQ-002 Parameter T_AY, default 2, required Ya-phase length in clk cycles.
REQ-003 Parameter T_BG, default 3, required Gb-phase length in clk cycles.
REQ-004 Parameter T_BY, default 2, required Yb-phase length in clk cycles.
REQ-005 Parameter T_WALK, default 2, required Gw-phase length in clk cycles.
REQ-006 Parameter T_FLASH, default 3, required flash-phase length in clk cycles.
REQ-007 clk  in  1  sole clock; all logic rising-edge.
REQ-008 rst  in  1  reset, synchronous and active-high.
REQ-009 Ra, Ya, Ga, Rb, Yb, Gb, Rw, Gw  in  1 each  light lines from the controller, same clk domain, no synchroniser.
REQ-010 phase  out  3  registered decoded phase: 0 AG, 1 AY, 2 BG, 3 BY, 4 WALK, 5 FLASH, 7 INVALID.
REQ-011 locked  out  1  high once the sequence checker is aligned.
REQ-012 err  out  1  sticky error flag.
REQ-013 err_code  out  3  code of the first error: 0 none, 1 illegal combination, 2 illegal transition, 3 short phase, 4 long phase, 5 no flash toggle.
REQ-014 rounds  out  16  count of completed AG->...->FLASH->AG cycles.

Function
REQ-015 The combinational decode SHALL be: AG = Ga&Rb&Rw only; AY = Ya&Rb&Rw only; BG = Ra&Gb&Rw only; BY = Ra&Yb&Rw only; WALK = Ra&Rb&Gw only; FLASH = Ra&Rb with Ya,Ga,Yb,Gb,Gw low and Rw either value; anything else INVALID.
REQ-016 phase SHALL present the decode of the previous cycle's inputs (1-cycle latency).
REQ-017 A run-length counter (8-bit, saturating at 255) SHALL hold the number of consecutive cycles of the current decoded phase, restarting at 1 on a phase change.
REQ-018 States: UNLOCKED, LOCKED. UNLOCKED->LOCKED on the first cycle whose decode is AG and whose previous decode was not AG; locked rises that cycle.
REQ-019 While LOCKED the only legal transitions SHALL be AG->AY->BG->BY->WALK->FLASH->AG; any other change raises code 2.
REQ-020 While LOCKED, on a phase change, a run length < T_x of the ended phase raises code 3.
REQ-021 While LOCKED, the cycle the run length reaches T_x+1 raises code 4, without waiting for the phase to end.
REQ-022 While LOCKED, FLASH ending with zero Rw rising edges observed during it raises code 5.
REQ-023 An INVALID decode raises code 1 in either state.
REQ-024 Errors in the same cycle SHALL be prioritised 1>2>3>4>5.
REQ-025 err/err_code SHALL latch the first error only; later errors do not overwrite them.
REQ-026 Any error SHALL return the checker to UNLOCKED (locked low next cycle); relock follows REQ-018.
REQ-027 rounds SHALL increment on each legal FLASH->AG transition while LOCKED, wrapping 65535->0.
REQ-028 The first AG after lock SHALL be duration-checked from its first cycle.

Reset
REQ-029 On rst high at a clk edge: phase=7, locked=0, err=0, err_code=0, rounds=0, run length=0, flash toggle count=0, state UNLOCKED.
REQ-030 rst asserted mid-phase SHALL discard the partial phase; no error is raised for it.

Structure
REQ-031 Phase codes, error codes and the default T_x values SHALL live in a shared package stoplight_pkg, also used by the controller bench.
REQ-032 The decode of REQ-015 SHALL be a sub-module light_decode (purely combinational); everything else is in stoplight_monitor.

Verification
REQ-033 Legal sequence at default T_x (4,2,3,2,2,3 cycles, Rw toggling each FLASH cycle) for 3 rounds -> locked=1 from the first AG, err=0, rounds=3.
REQ-034 Ga and Gb both high for 1 cycle -> err=1, err_code=1, locked=0 next cycle.
REQ-035 After lock, AY held 1 cycle then BG -> err_code=3.
REQ-036 After lock, BG held 4 cycles -> err_code=4 on the 4th cycle of BG.
REQ-037 After lock, AG->BG directly with long AG -> err_code=4 (asserted first), not 2; separately AG of exactly 4 cycles then BG -> err_code=2.
REQ-038 FLASH held 3 cycles with Rw constant 1 -> err_code=5; then rst mid-BG -> all outputs at reset values, and a subsequent legal round gives rounds=1.
